// File: rtl/spike_delay_dispatcher_pkg.sv
// Shared SNN definitions for the spike delay dispatcher.
// Delay-code width, history depth and FSM state encoding.
package spike_delay_dispatcher_pkg;

  localparam int DCODE_W = 2;
  localparam int HIST_D  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EMIT   = 2'd2
  } state_e;

endpackage

// File: rtl/spike_delay_line.sv
// One synapse: shift-register spike history plus
// a tap mux selecting the spike from delay_i steps ago.
module spike_delay_line
  import spike_delay_dispatcher_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               spike_i,
  input  logic [DCODE_W-1:0] delay_i,
  output logic               tap_o
);

  logic [HIST_D-1:0] hist_q;

  // Newest spike enters at bit 0 on each processed step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
    end else if (shift_i) begin
      hist_q <= {hist_q[HIST_D-2:0], spike_i};
    end
  end

  assign tap_o = hist_q[delay_i];

endmodule

// File: rtl/spike_delay_dispatcher.sv
// Per-synapse delayed spike dispatch with a one-deep
// step buffer and valid/ready output handshake.
module spike_delay_dispatcher
  import spike_delay_dispatcher_pkg::*;
#(
  parameter int M    = 24,
  parameter int DMAX = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           step,
  input  logic [M-1:0]   spike_in,
  input  logic [2*M-1:0] delays,
  output logic [M-1:0]   spikes_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           overrun,
  output logic [7:0]     timestep
);

  state_e       state_q, state_d;
  logic         valid_q, valid_d;
  logic         pend_q, pend_d;
  logic [M-1:0] pvec_q, pvec_d;
  logic         ovr_q, ovr_d;
  logic [7:0]   ts_q, ts_d;
  logic [M-1:0] out_q;
  logic [M-1:0] svec;
  logic [M-1:0] tap;
  logic         shift;
  logic         load;

  // Next-state, buffering and history control.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    pvec_d  = pvec_q;
    ovr_d   = ovr_q;
    ts_d    = ts_q;
    shift   = 1'b0;
    load    = 1'b0;
    svec    = pend_q ? pvec_q : spike_in;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q || step) begin
          shift   = 1'b1;
          ts_d    = ts_q + 8'd1;
          state_d = ST_SELECT;
          if (pend_q) begin
            if (step) pvec_d = spike_in;
            else      pend_d = 1'b0;
          end
        end
      end
      ST_SELECT: begin
        load    = 1'b1;
        valid_d = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (step && (state_q != ST_IDLE)) begin
      if (!pend_q) begin
        pend_d = 1'b1;
        pvec_d = spike_in;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (clear) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      pend_d  = 1'b0;
      pvec_d  = '0;
      ovr_d   = 1'b0;
      ts_d    = '0;
      shift   = 1'b0;
      load    = 1'b0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      pvec_q  <= '0;
      ovr_q   <= 1'b0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      pvec_q  <= pvec_d;
      ovr_q   <= ovr_d;
      ts_q    <= ts_d;
    end
  end

  // Output vector captured in SELECT, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else if (load) begin
      out_q <= tap;
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_syn
    logic [DCODE_W-1:0] code;
    logic [DCODE_W-1:0] dsel;
    assign code = delays[DCODE_W*i +: DCODE_W];
    assign dsel = (code > DCODE_W'(DMAX)) ?
                  DCODE_W'(DMAX) : code;
    spike_delay_line u_line (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear),
      .shift_i (shift),
      .spike_i (svec[i]),
      .delay_i (dsel),
      .tap_o   (tap[i])
    );
  end

  assign spikes_out = out_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = ovr_q;
  assign timestep   = ts_q;

endmodule
